// File: rtl/bcd_digit_builder.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_builder
// Description : Sequential signed-binary to 4-digit display-code converter.
//               It uses a double-dabble (shift-add-3) engine, then places the
//               sign, optionally blanks leading zeros, and flags overflow.
//               All four digit codes update together on the FORMAT edge.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Build option: define LZ_BLANK_EN to enable leading-zero blanking.
// ----------------------------------------------------------------------------
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   value_i    in   WIDTH  signed operand, captured on an accepted start
//   start_i    in   1      conversion request (only honoured in IDLE)
//   busy_o     out  1      conversion in progress
//   done_o     out  1      one-cycle pulse, new digits valid from this cycle
//   overflow_o out  1      last result not displayable
//   digit1_o   out  8      units code (rightmost)
//   digit2_o   out  8      tens code
//   digit3_o   out  8      hundreds code
//   digit4_o   out  8      thousands code (leftmost)
// Digit codes: 0-9 decimal, 10 minus, 11 blank, 12 letter E.
// ============================================================================
module bcd_digit_builder #(
  parameter int WIDTH = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] value_i,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             overflow_o,
  output logic [7:0]       digit1_o,
  output logic [7:0]       digit2_o,
  output logic [7:0]       digit3_o,
  output logic [7:0]       digit4_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_SHIFT  = 2'd2,
    S_FORMAT = 2'd3
  } state_t;

  localparam int         c_CNT_W = $clog2(WIDTH + 1);
  localparam logic [7:0] c_MINUS = 8'd10;
  localparam logic [7:0] c_BLANK = 8'd11;
  localparam logic [7:0] c_E     = 8'd12;
`ifdef LZ_BLANK_EN
  localparam logic [7:0] c_RST_HI = c_BLANK;
`else
  localparam logic [7:0] c_RST_HI = 8'd0;
`endif

  state_t             state_q;
  logic [WIDTH-1:0]   operand_q;
  logic               neg_q;
  logic [WIDTH:0]     mag_q;
  logic [WIDTH:0]     mag_d;
  logic [19:0]        bcd_q;
  logic [19:0]        bcd_d;
  logic [c_CNT_W-1:0] cnt_q;
  logic               busy_q;
  logic               done_q;
  logic               ovf_q;
  logic [7:0]         digit1_q;
  logic [7:0]         digit2_q;
  logic [7:0]         digit3_q;
  logic [7:0]         digit4_q;

  // Magnitude in WIDTH+1 bits so the most negative operand does not wrap.
  logic [WIDTH:0] sext_w;
  logic [WIDTH:0] mag_w;
  assign sext_w = {operand_q[WIDTH-1], operand_q};
  assign mag_w  = operand_q[WIDTH-1] ? -sext_w : sext_w;

  // One double-dabble step. The magnitude register is WIDTH+1 bits wide and
  // its top bit is always zero, so the engine runs WIDTH+1 steps with the
  // first one shifting in that zero guard bit. The fifth decade can never
  // reach 5 before the final shift (magnitude <= 32768), so it only shifts.
  logic [15:0] bcd_adj_w;
  always_comb begin
    bcd_adj_w = bcd_q[15:0];
    for (int j = 0; j < 4; j++) begin
      if (bcd_q[4*j +: 4] >= 4'd5) begin
        bcd_adj_w[4*j +: 4] = bcd_q[4*j +: 4] + 4'd3;
      end
    end
    bcd_d = {bcd_q[18:16], bcd_adj_w, mag_q[WIDTH]};
    mag_d = {mag_q[WIDTH-1:0], 1'b0};
  end

  // Result formatting from the finished BCD decades.
  logic       ovf_w;
  logic [7:0] dig_w [4];
`ifdef LZ_BLANK_EN
  logic [1:0] msd_w;  // index of the most significant non-zero decade
`endif
  always_comb begin
    // A negative value needs one position for the minus sign.
    if (neg_q) begin
      ovf_w = (bcd_q[19:12] != 8'd0);
    end else begin
      ovf_w = (bcd_q[19:16] != 4'd0);
    end
`ifdef LZ_BLANK_EN
    msd_w = 2'd0;
    for (int i = 1; i < 4; i++) begin
      if (bcd_q[4*i +: 4] != 4'd0) begin
        msd_w = 2'(i);
      end
    end
`endif
    for (int i = 0; i < 4; i++) begin
`ifdef LZ_BLANK_EN
      if (i <= int'(msd_w)) begin
        dig_w[i] = {4'd0, bcd_q[4*i +: 4]};
      end else if (neg_q && (i == int'(msd_w) + 1)) begin
        dig_w[i] = c_MINUS;
      end else begin
        dig_w[i] = c_BLANK;
      end
`else
      if (neg_q && (i == 3)) begin
        dig_w[i] = c_MINUS;
      end else begin
        dig_w[i] = {4'd0, bcd_q[4*i +: 4]};
      end
`endif
      if (ovf_w) begin
        dig_w[i] = (i == 3) ? c_E : c_BLANK;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      operand_q <= '0;
      neg_q     <= 1'b0;
      mag_q     <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      digit1_q  <= 8'd0;
      digit2_q  <= c_RST_HI;
      digit3_q  <= c_RST_HI;
      digit4_q  <= c_RST_HI;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            operand_q <= value_i;
            state_q   <= S_LOAD;
          end
        end
        S_LOAD: begin
          neg_q   <= operand_q[WIDTH-1];
          mag_q   <= mag_w;
          bcd_q   <= '0;
          cnt_q   <= c_CNT_W'(WIDTH);
          busy_q  <= 1'b1;
          state_q <= S_SHIFT;
        end
        S_SHIFT: begin
          bcd_q <= bcd_d;
          mag_q <= mag_d;
          if (cnt_q == '0) begin
            state_q <= S_FORMAT;
          end else begin
            cnt_q <= cnt_q - c_CNT_W'(1);
          end
        end
        S_FORMAT: begin
          digit1_q <= dig_w[0];
          digit2_q <= dig_w[1];
          digit3_q <= dig_w[2];
          digit4_q <= dig_w[3];
          ovf_q    <= ovf_w;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign overflow_o = ovf_q;
  assign digit1_o   = digit1_q;
  assign digit2_o   = digit2_q;
  assign digit3_o   = digit3_q;
  assign digit4_o   = digit4_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_digit_builder.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_digit_builder
// Description : Scoreboard bench for bcd_digit_builder (WIDTH=14). Stimulus
//               pushes the reference-model result; a negedge monitor pops it
//               whenever done is seen and also checks latency, busy length,
//               output hold and stray done pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_digit_builder;

  localparam int WIDTH = 14;
`ifdef LZ_BLANK_EN
  localparam logic [7:0] c_RST_HI = 8'd11;
`else
  localparam logic [7:0] c_RST_HI = 8'd0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [WIDTH-1:0] value_i = '0;
  logic             start_i = 1'b0;
  logic             busy_o;
  logic             done_o;
  logic             overflow_o;
  logic [7:0]       digit1_o;
  logic [7:0]       digit2_o;
  logic [7:0]       digit3_o;
  logic [7:0]       digit4_o;

  bcd_digit_builder #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value_i    (value_i),
    .start_i    (start_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .overflow_o (overflow_o),
    .digit1_o   (digit1_o),
    .digit2_o   (digit2_o),
    .digit3_o   (digit3_o),
    .digit4_o   (digit4_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [32:0] res;  // {overflow, digit4, digit3, digit2, digit1}
    int          due;  // cyc value at the negedge where done must be seen
    int          val;
  } exp_t;

  exp_t q[$];
  int   tot = 0;
  int   bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tot++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: decimal arithmetic on the signed integer.
  function automatic logic [32:0] model(input int v);
    int         m;
    bit         neg;
    bit         ovf;
    int         nd;
    int         p;
    int         dec[4];
    logic [7:0] d[4];
    neg = (v < 0);
    m   = neg ? -v : v;
    ovf = neg ? (m > 999) : (m > 9999);
    p = 1;
    for (int i = 0; i < 4; i++) begin
      dec[i] = (m / p) % 10;
      p = p * 10;
    end
    nd = 1;
    p  = 10;
    while (nd < 4 && m >= p) begin
      nd++;
      p = p * 10;
    end
    for (int i = 0; i < 4; i++) begin
      if (ovf) d[i] = (i == 3) ? 8'd12 : 8'd11;
`ifdef LZ_BLANK_EN
      else if (i < nd) d[i] = 8'(dec[i]);
      else if (neg && i == nd) d[i] = 8'd10;
      else d[i] = 8'd11;
`else
      else if (neg && i == 3) d[i] = 8'd10;
      else d[i] = 8'(dec[i]);
`endif
    end
    return {ovf, d[3], d[2], d[1], d[0]};
  endfunction

  function automatic logic [32:0] cur_out();
    return {overflow_o, digit4_o, digit3_o, digit2_o, digit1_o};
  endfunction

  // Monitor / scoreboard
  logic [32:0] prev;
  int          busy_run = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      busy_run = 0;
      prev     = cur_out();
    end else begin
      if (busy_o) busy_run++;
      if (done_o) begin
        if (q.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          check($sformatf("result(%0d)", e.val), 64'(cur_out()), 64'(e.res));
          check($sformatf("latency(%0d)", e.val), 64'(cyc), 64'(e.due));
          check("busy_len", 64'(busy_run), 64'(WIDTH + 2));
          check("busy_in_done", 64'(busy_o), 64'd0);
        end
        busy_run = 0;
      end else begin
        check("hold", 64'(cur_out()), 64'(prev));
      end
      prev = cur_out();
    end
  end

  // Call at a negedge; leaves start low one negedge later.
  task automatic issue(input int v);
    logic [WIDTH-1:0] b;
    exp_t             e;
    b       = v[WIDTH-1:0];
    value_i = b;
    start_i = 1'b1;
    e.res   = model($signed(b));
    e.due   = cyc + 1 + WIDTH + 3;
    e.val   = $signed(b);
    q.push_back(e);
    @(negedge clk);
    start_i = 1'b0;
  endtask

  // Returns at the negedge where done is high, or flags a timeout.
  task automatic wait_done();
    int n;
    n = 0;
    while (!done_o && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!done_o) check("done_timeout", 64'd1, 64'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, 64'(busy_o), 64'd0);
    check({tag, "_done"}, 64'(done_o), 64'd0);
    check({tag, "_digits"}, 64'(cur_out()), 64'({1'b0, c_RST_HI, c_RST_HI, c_RST_HI, 8'd0}));
  endtask

  initial begin
    int dir[] = '{1234, -42, 0, -8192, 8191, -999, -1000, -1, 9, 10, 99,
                  100, -9, -10, -99, -100, 1000, 7, 10000, 9999};

    #2 rst_n = 1'b0;
    #1 check_reset_vals("reset");
    repeat (3) @(negedge clk);
    check_reset_vals("reset_held");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    foreach (dir[i]) begin
      issue(dir[i]);
      wait_done();
      @(negedge clk);
    end

    // Back-to-back: second start held in the done cycle
    issue(-1000);
    wait_done();
    issue(-999);
    wait_done();
    issue(8000);
    wait_done();
    issue(-8191);
    wait_done();
    @(negedge clk);

    // Start while busy is ignored
    issue(55);
    repeat (3) @(negedge clk);
    value_i = 14'd77;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    wait_done();
    repeat (25) @(negedge clk);

    // Randomized conversions with random gaps
    for (int k = 0; k < 40; k++) begin
      issue(int'($urandom_range(16383, 0)));
      wait_done();
      repeat ($urandom_range(2, 0)) @(negedge clk);
    end
    @(negedge clk);

    // Reset mid-conversion aborts it
    issue(1234);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    q.delete();
    #1 check_reset_vals("abort");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check_reset_vals("after_abort");

    issue(-5);
    wait_done();
    repeat (3) @(negedge clk);

    check("queue_empty", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
`default_nettype wire
